morse_digit_buffer: RTL and testbench

MORSE_DIGIT_BUFFER -- requirements
Module: morse_digit_buffer

---
 rtl/morse_digit_buffer.sv | 159 +++++++++++++++
 tb/tb_morse_digit_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_digit_buffer.sv
// -----------------------------------------------------------------------------
// morse_digit_buffer
//   Eight-digit shift buffer between a Morse decoder and a multiplexed
//   7-segment display scanner. New digits enter at position 0 (rightmost) and
//   push older digits left. Codes 10..15 are stored as BLANK_CODE.
//
//   Optional feature: define MORSE_DIGIT_BUFFER_BACKSPACE_EN to add the
//   backspace port (remove newest digit). Without it only clear and accept
//   modify the buffer.
//
// Parameters
//   SCROLL      1: drop the oldest digit when full; 0: refuse input when full
//   BLANK_CODE  digit code the scanner renders as an unlit position
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    upstream offers in_digit
//   in_digit    offered digit code
//   in_ready    buffer takes in_digit this cycle (combinational)
//   clear       one-cycle command: blank all positions
//   backspace   one-cycle command: drop newest digit (feature macro only)
//   scan_sel    position requested by the scanner, 0 = rightmost
//   digit_out   registered code of position scan_sel, 1 clk latency
//   fill_count  number of occupied positions, 0..8
//   full        fill_count == 8 (combinational from the register)
// -----------------------------------------------------------------------------
module morse_digit_buffer #(
    parameter int unsigned SCROLL     = 1,
    parameter logic [3:0]  BLANK_CODE = 4'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_digit,
    output logic       in_ready,
    input  logic       clear,
`ifdef MORSE_DIGIT_BUFFER_BACKSPACE_EN
    input  logic       backspace,
`endif
    input  logic [2:0] scan_sel,
    output logic [3:0] digit_out,
    output logic [3:0] fill_count,
    output logic       full
);

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 4;
    localparam int unsigned CW    = 4;

    // ST_INIT covers reset and the first edge after it, when no digit may enter
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [DW-1:0] r_entry     [DEPTH];
    logic [DW-1:0] w_entry_nxt [DEPTH];
    logic [CW-1:0] r_fill_count;
    logic [CW-1:0] w_fill_nxt;
    logic [DW-1:0] r_digit_out;
    logic [DW-1:0] w_digit_norm;
    logic          w_bs_cmd;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_full;

`ifdef MORSE_DIGIT_BUFFER_BACKSPACE_EN
    assign w_bs_cmd = backspace;
`else
    assign w_bs_cmd = 1'b0;
`endif

    assign w_full       = (r_fill_count == CW'(DEPTH));
    assign w_accept     = in_valid && w_in_ready;
    // Non-decimal codes are shown as an unlit position but still occupy a slot
    assign w_digit_norm = (in_digit > 4'd9) ? BLANK_CODE : in_digit;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake; any command stalls upstream so its digit is kept
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_in_ready = !clear && !w_bs_cmd && ((SCROLL != 0) || !w_full);
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Buffer update with priority clear > backspace > accept
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_entry_nxt[i] = r_entry[i];
        end
        w_fill_nxt = r_fill_count;
        if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                w_entry_nxt[i] = BLANK_CODE;
            end
            w_fill_nxt = '0;
        end else if (w_bs_cmd && (r_fill_count != '0)) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                w_entry_nxt[i] = r_entry[i + 1];
            end
            w_entry_nxt[DEPTH-1] = BLANK_CODE;
            w_fill_nxt           = r_fill_count - CW'(1);
        end else if (w_accept) begin
            // Oldest entry falls off the left; when not full it is blank anyway
            for (int unsigned i = 1; i < DEPTH; i++) begin
                w_entry_nxt[i] = r_entry[i - 1];
            end
            w_entry_nxt[0] = w_digit_norm;
            if (!w_full) begin
                w_fill_nxt = r_fill_count + CW'(1);
            end
        end
    end

    // Storage, count and scanner read port (reads the post-update contents)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entry[i] <= BLANK_CODE;
            end
            r_fill_count <= '0;
            r_digit_out  <= BLANK_CODE;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entry[i] <= w_entry_nxt[i];
            end
            r_fill_count <= w_fill_nxt;
            r_digit_out  <= w_entry_nxt[scan_sel];
        end
    end

    assign in_ready   = w_in_ready;
    assign digit_out  = r_digit_out;
    assign fill_count = r_fill_count;
    assign full       = w_full;

endmodule

// File: tb/tb_morse_digit_buffer.sv
// -----------------------------------------------------------------------------
// tb_morse_digit_buffer
//   Drives one SCROLL=1 and one SCROLL=0 instance with the same stimulus and
//   compares both against a list model: each buffer is a queue of occupied
//   digits, newest first; positions past the end of the queue read as blank.
// -----------------------------------------------------------------------------
module tb_morse_digit_buffer;

    localparam logic [3:0] BLANK = 4'd10;

    typedef logic [3:0] nib_q_t [$];

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       in_valid  = 1'b0;
    logic [3:0] in_digit  = 4'd0;
    logic       clear     = 1'b0;
    logic       backspace = 1'b0;
    logic [2:0] scan_sel  = 3'd0;

    logic       rdy1, rdy0, full1, full0;
    logic [3:0] dout1, dout0, cnt1, cnt0;

    int         n_tests = 0;
    int         n_fail  = 0;

    nib_q_t     q_scroll;
    nib_q_t     q_hold;
    bit         first_edge = 1'b1;

    morse_digit_buffer #(.SCROLL(1), .BLANK_CODE(BLANK)) u_dut_scroll (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_digit   (in_digit),
        .in_ready   (rdy1),
        .clear      (clear),
`ifdef MORSE_DIGIT_BUFFER_BACKSPACE_EN
        .backspace  (backspace),
`endif
        .scan_sel   (scan_sel),
        .digit_out  (dout1),
        .fill_count (cnt1),
        .full       (full1)
    );

    morse_digit_buffer #(.SCROLL(0), .BLANK_CODE(BLANK)) u_dut_hold (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_digit   (in_digit),
        .in_ready   (rdy0),
        .clear      (clear),
`ifdef MORSE_DIGIT_BUFFER_BACKSPACE_EN
        .backspace  (backspace),
`endif
        .scan_sel   (scan_sel),
        .digit_out  (dout0),
        .fill_count (cnt0),
        .full       (full0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int q_at(input nib_q_t q, input int i);
        return (i < q.size()) ? int'(q[i]) : int'(BLANK);
    endfunction

    function automatic bit exp_ready(input bit scroll, input int size);
        return !first_edge && !clear && !backspace && (scroll || (size < 8));
    endfunction

    // One edge of the list model, using the inputs currently driven
    function automatic nib_q_t model_next(input nib_q_t q, input bit rdy);
        nib_q_t r;
        r = q;
        if (clear) begin
            r.delete();
        end else if (backspace) begin
            if (r.size() > 0) r.delete(0);
        end else if (in_valid && rdy) begin
            r.push_front((in_digit > 4'd9) ? BLANK : in_digit);
            if (r.size() > 8) r.delete(8);
        end
        return r;
    endfunction

    // One clock: drive just after a negedge, check in_ready, step model, check outputs
    task automatic cyc(input bit vld, input logic [3:0] d, input bit clr,
                       input bit bs, input logic [2:0] sel);
        bit er1, er0;
        in_valid  = vld;
        in_digit  = d;
        clear     = clr;
        backspace = bs;
        scan_sel  = sel;
        #1;
        er1 = exp_ready(1'b1, q_scroll.size());
        er0 = exp_ready(1'b0, q_hold.size());
        check("in_ready_scroll", int'(rdy1), int'(er1));
        check("in_ready_hold", int'(rdy0), int'(er0));
        @(posedge clk);
        q_scroll   = model_next(q_scroll, er1);
        q_hold     = model_next(q_hold, er0);
        first_edge = 1'b0;
        @(negedge clk);
        in_valid  = 1'b0;
        clear     = 1'b0;
        backspace = 1'b0;
        check("digit_out_scroll", int'(dout1), q_at(q_scroll, int'(sel)));
        check("digit_out_hold", int'(dout0), q_at(q_hold, int'(sel)));
        check("fill_scroll", int'(cnt1), q_scroll.size());
        check("fill_hold", int'(cnt0), q_hold.size());
        check("full_scroll", int'(full1), int'(q_scroll.size() == 8));
        check("full_hold", int'(full0), int'(q_hold.size() == 8));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dout_scroll"}, int'(dout1), int'(BLANK));
        check({tag, "_dout_hold"}, int'(dout0), int'(BLANK));
        check({tag, "_fill_scroll"}, int'(cnt1), 0);
        check({tag, "_fill_hold"}, int'(cnt0), 0);
        check({tag, "_full_scroll"}, int'(full1), 0);
        check({tag, "_full_hold"}, int'(full0), 0);
        check({tag, "_rdy_scroll"}, int'(rdy1), 0);
        check({tag, "_rdy_hold"}, int'(rdy0), 0);
    endtask

    // Mid-cycle reset with a digit pending; called just after a negedge
    task automatic async_reset();
        in_valid = 1'b1;
        in_digit = 4'd6;
        #2 rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_reset_values("rst_held");
        in_valid = 1'b0;
        rst      = 1'b0;
        q_scroll.delete();
        q_hold.delete();
        first_edge = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         r_vld, r_clr, r_bs;
        logic [3:0] r_d;
        logic [2:0] r_sel;

        // Power-on reset
        @(negedge clk);
        check_reset_values("por");
        rst = 1'b0;
        q_scroll.delete();
        q_hold.delete();
        first_edge = 1'b1;

        // Digits 1,2,3 read back by position; first edge refuses input
        cyc(1'b1, 4'd9, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 4'd1, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 4'd2, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 4'd3, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        check("s031_pos0", int'(dout1), 3);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd1);
        check("s031_pos1", int'(dout1), 2);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd2);
        check("s031_pos2", int'(dout1), 1);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd3);
        check("s031_pos3", int'(dout1), 10);
        check("s031_fill", int'(cnt1), 3);

        // Nine digits 0..8: scroll drops the oldest, hold refuses the ninth
        async_reset();
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 9; k++) begin
            cyc(1'b1, 4'(k), 1'b0, 1'b0, 3'd0);
        end
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd7);
        check("s032_pos7", int'(dout1), 1);
        check("s033_pos7", int'(dout0), 0);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        check("s032_pos0", int'(dout1), 8);
        check("s032_fill", int'(cnt1), 8);
        check("s032_full", int'(full1), 1);
        check("s032_ready", int'(rdy1), 1);
        check("s033_ready", int'(rdy0), 0);
        cyc(1'b1, 4'd9, 1'b0, 1'b0, 3'd0);
        check("s033_unchanged", int'(dout0), 7);
        check("s033_fill", int'(cnt0), 8);

        // Clear beats a pending digit, which is then taken on the next cycle
        cyc(1'b1, 4'd5, 1'b1, 1'b0, 3'd4);
        check("s035_blank", int'(dout1), 10);
        check("s035_fill", int'(cnt1), 0);
        cyc(1'b1, 4'd5, 1'b0, 1'b0, 3'd0);
        check("s035_retry", int'(dout1), 5);

        // Code 13 stored blank but counted, then reset mid-cycle
        cyc(1'b1, 4'd4, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 4'd13, 1'b0, 1'b0, 3'd0);
        check("s036_blank", int'(dout1), 10);
        check("s036_fill", int'(cnt1), 3);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd1);
        check("s036_pos1", int'(dout1), 4);
        async_reset();

`ifdef MORSE_DIGIT_BUFFER_BACKSPACE_EN
        // Backspace removes newest digit and never underflows
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 4'd7, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 4'd5, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 4'd9, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 4'd2, 1'b0, 1'b1, 3'd0);
        check("s034_pos0", int'(dout1), 5);
        check("s034_fill", int'(cnt1), 2);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd1);
        check("s034_pos1", int'(dout1), 7);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 4'd0, 1'b0, 1'b1, 3'd0);
        end
        check("s034_empty", int'(cnt1), 0);
`endif

        // Random traffic against the list model
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
            end else begin
                r_vld = ($urandom_range(0, 9) < 7);
                r_d   = 4'($urandom_range(0, 15));
                r_clr = ($urandom_range(0, 24) == 0);
                r_sel = 3'($urandom_range(0, 7));
                r_bs  = 1'b0;
`ifdef MORSE_DIGIT_BUFFER_BACKSPACE_EN
                r_bs  = ($urandom_range(0, 7) == 0);
`endif
                cyc(r_vld, r_d, r_clr, r_bs, r_sel);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
